// File: rtl/serial_parity_engine_if.sv
// Serial parity engine bus: bit stream in, parity/status strobes and error count out.
// Latency: n/a (signal bundle only).
// Backpressure: none; the engine accepts every bit_vld cycle. Sticky flag present when PARITY_STICKY_ERR_EN is defined.
interface serial_parity_engine_if #(
   parameter int ERR_CNT_W = 8
);
   logic                 bit_in;
   logic                 bit_vld;
   logic                 odd_mode;
   logic                 chk_mode;
   logic                 clr;
   logic                 p_out;
   logic                 p_vld;
   logic                 frame_done;
   logic                 err;
   logic                 busy;
   logic [ERR_CNT_W-1:0] err_cnt;
`ifdef PARITY_STICKY_ERR_EN
   logic                 err_sticky;

   modport master (
      output bit_in, bit_vld, odd_mode, chk_mode, clr,
      input  p_out, p_vld, frame_done, err, busy, err_cnt, err_sticky
   );
   modport slave (
      input  bit_in, bit_vld, odd_mode, chk_mode, clr,
      output p_out, p_vld, frame_done, err, busy, err_cnt, err_sticky
   );
`else
   modport master (
      output bit_in, bit_vld, odd_mode, chk_mode, clr,
      input  p_out, p_vld, frame_done, err, busy, err_cnt
   );
   modport slave (
      input  bit_in, bit_vld, odd_mode, chk_mode, clr,
      output p_out, p_vld, frame_done, err, busy, err_cnt
   );
`endif
endinterface

// File: rtl/serial_parity_engine.sv
// Serial parity generator/checker over FRAME_LEN-bit frames with saturating error counter; PARITY_STICKY_ERR_EN adds err_sticky.
// Latency: p_vld/frame_done/err strobe 1 cycle after the edge accepting the last frame bit.
// Backpressure: none; every bit_vld cycle is consumed, a bit in a strobe cycle starts the next frame.
module serial_parity_engine #(
   parameter int FRAME_LEN = 8,
   parameter int ERR_CNT_W = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   serial_parity_engine_if.slave  bus
);
   localparam int CNT_W = $clog2(FRAME_LEN + 1);
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

   typedef enum logic [1:0] {IDLE, DATA, PAR} state_t;

   state_t               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 acc_q, acc_d;
   logic                 odd_q, odd_d;
   logic                 chk_q, chk_d;
   logic                 p_out_q, p_out_d;
   logic                 p_vld_q, p_vld_d;
   logic                 fd_q, fd_d;
   logic                 err_q, err_d;
   logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
   logic                 acc_nxt;

   // running parity including the bit offered this cycle
   assign acc_nxt = acc_q ^ bus.bit_in;

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // frame datapath, latched modes and registered strobes
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q     <= '0;
         acc_q     <= 1'b0;
         odd_q     <= 1'b0;
         chk_q     <= 1'b0;
         p_out_q   <= 1'b0;
         p_vld_q   <= 1'b0;
         fd_q      <= 1'b0;
         err_q     <= 1'b0;
         err_cnt_q <= '0;
      end else begin
         cnt_q     <= cnt_d;
         acc_q     <= acc_d;
         odd_q     <= odd_d;
         chk_q     <= chk_d;
         p_out_q   <= p_out_d;
         p_vld_q   <= p_vld_d;
         fd_q      <= fd_d;
         err_q     <= err_d;
         err_cnt_q <= err_cnt_d;
      end
   end

   // next state, datapath and strobes; clr wins over an incoming bit
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      acc_d     = acc_q;
      odd_d     = odd_q;
      chk_d     = chk_q;
      p_out_d   = p_out_q;
      p_vld_d   = 1'b0;
      fd_d      = 1'b0;
      err_d     = 1'b0;
      err_cnt_d = err_cnt_q;
      if (bus.clr) begin
         state_d   = IDLE;
         cnt_d     = '0;
         acc_d     = 1'b0;
         err_cnt_d = '0;
      end else if (bus.bit_vld) begin
         case (state_q)
            IDLE: begin
               // modes are frozen for the whole frame at its first bit
               odd_d   = bus.odd_mode;
               chk_d   = bus.chk_mode;
               acc_d   = bus.bit_in;
               cnt_d   = CNT_W'(1);
               state_d = DATA;
            end
            DATA: begin
               acc_d = acc_nxt;
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_q == LAST_IDX) begin
                  if (chk_q) begin
                     state_d = PAR;
                  end else begin
                     state_d = IDLE;
                     cnt_d   = '0;
                     acc_d   = 1'b0;
                     p_vld_d = 1'b1;
                     fd_d    = 1'b1;
                     p_out_d = acc_nxt ^ odd_q;
                  end
               end
            end
            PAR: begin
               // acc_nxt folds in the received parity bit
               state_d = IDLE;
               cnt_d   = '0;
               acc_d   = 1'b0;
               fd_d    = 1'b1;
               err_d   = acc_nxt ^ odd_q;
               if (err_d && (err_cnt_q != {ERR_CNT_W{1'b1}}))
                  err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
            end
            default: state_d = IDLE;
         endcase
      end
   end

   assign bus.p_out      = p_out_q;
   assign bus.p_vld      = p_vld_q;
   assign bus.frame_done = fd_q;
   assign bus.err        = err_q;
   assign bus.busy       = (state_q != IDLE);
   assign bus.err_cnt    = err_cnt_q;

`ifdef PARITY_STICKY_ERR_EN
   logic sticky_q;

   // sticky error flag, only clr or reset clears it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       sticky_q <= 1'b0;
      else if (bus.clr) sticky_q <= 1'b0;
      else if (err_d)   sticky_q <= 1'b1;
   end

   assign bus.err_sticky = sticky_q;
`endif
endmodule
